// File: rtl/cv32e40p_regfile_pkg.sv
// Shared types and default geometry for the multi-port latch register file.
package cv32e40p_regfile_pkg;

    typedef enum logic [1:0] {
        CLR_IDLE  = 2'd0,
        CLR_SWEEP = 2'd1,
        CLR_DONE  = 2'd2
    } clr_state_e;

    localparam int RF_ADDR_WIDTH = 5;
    localparam int RF_DATA_WIDTH = 32;
    localparam int RF_NUM_WR     = 2;
    localparam int RF_NUM_RD     = 3;
    localparam int RF_ZERO_REG   = 1;
    localparam int RF_FWD_EN     = 1;

endpackage

// File: rtl/cv32e40p_clock_gate.sv
// Latch-based integrated clock gate: enable captured while clk_i is low, output glitch-free.
// Zero latency; scan_cg_en_i forces the gate open.
module cv32e40p_clock_gate (
    input  logic clk_i,
    input  logic en_i,
    input  logic scan_cg_en_i,
    output logic clk_o
);

    logic en_latch;

    always_latch begin
        if (!clk_i) begin
            en_latch <= en_i | scan_cg_en_i;
        end
    end

    assign clk_o = clk_i & en_latch;

endmodule

// File: rtl/cv32e40p_regfile_clear_fsm.sv
// Zeroing sweep controller: walks one word per cycle from the first writable word to the last.
// Starts the cycle after clear_req_i in IDLE; requests are ignored while sweeping or done.
module cv32e40p_regfile_clear_fsm
    import cv32e40p_regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int ZERO_REG   = RF_ZERO_REG
) (
    input  logic                  clk_int,
    input  logic                  rst_n,
    input  logic                  clear_req_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] sweep_addr_o
);

    localparam logic [ADDR_WIDTH-1:0] FIRST_WORD = ADDR_WIDTH'((ZERO_REG != 0) ? 1 : 0);
    localparam logic [ADDR_WIDTH-1:0] LAST_WORD  = '1;

    clr_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_int or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLR_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLR_IDLE: begin
                if (clear_req_i) begin
                    state_d = CLR_SWEEP;
                    cnt_d   = FIRST_WORD;
                end
            end
            CLR_SWEEP: begin
                // Stop on the last word rather than letting the counter wrap.
                if (cnt_q == LAST_WORD) begin
                    state_d = CLR_DONE;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            CLR_DONE: begin
                state_d = CLR_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = CLR_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        busy_o       = (state_q == CLR_SWEEP);
        done_o       = (state_q == CLR_DONE);
        sweep_addr_o = cnt_q;
    end

endmodule

// File: rtl/cv32e40p_regfile_latch_mp.sv
// Multi-port latch register file: combinational reads, writes staged one cycle then latched via per-word clock gates.
// Write visible next cycle; no backpressure, external writes are dropped while the clear sweep runs.
module cv32e40p_regfile_latch_mp
    import cv32e40p_regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int NUM_WR     = RF_NUM_WR,
    parameter int NUM_RD     = RF_NUM_RD,
    parameter int ZERO_REG   = RF_ZERO_REG,
    parameter int FWD_EN     = RF_FWD_EN
) (
    input  logic                                clk_int,
    input  logic                                rst_n,
    input  logic                                scan_cg_en_i,
    input  logic [NUM_RD-1:0][ADDR_WIDTH-1:0]   raddr_i,
    output logic [NUM_RD-1:0][DATA_WIDTH-1:0]   rdata_o,
    input  logic [NUM_WR-1:0][ADDR_WIDTH-1:0]   waddr_i,
    input  logic [NUM_WR-1:0][DATA_WIDTH-1:0]   wdata_i,
    input  logic [NUM_WR-1:0]                   we_i,
    input  logic                                clear_req_i,
    output logic                                clear_busy_o,
    output logic                                clear_done_o
);

    localparam int NUM_WORDS  = 2 ** ADDR_WIDTH;
    localparam int FIRST_WORD = (ZERO_REG != 0) ? 1 : 0;

    logic                                clr_busy;
    logic                                clr_done;
    logic [ADDR_WIDTH-1:0]               clr_addr;
    logic [NUM_WR-1:0]                   we_eff;
    logic [NUM_WR-1:0][DATA_WIDTH-1:0]   wdata_d, wdata_q;
    logic [NUM_WR-1:0][NUM_WORDS-1:0]    waddr_oh_d, waddr_oh_q;
    logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] mem_rd;
    logic                                g_en;
    logic                                clk_g_raw;
    logic                                clk_g;

    cv32e40p_regfile_clear_fsm #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_REG   (ZERO_REG)
    ) u_clear_fsm (
        .clk_int      (clk_int),
        .rst_n        (rst_n),
        .clear_req_i  (clear_req_i),
        .busy_o       (clr_busy),
        .done_o       (clr_done),
        .sweep_addr_o (clr_addr)
    );

    assign clear_busy_o = clr_busy;
    assign clear_done_o = clr_done;

    // The sweep borrows port 0's staging slot; zero-address writes never set a one-hot bit.
    always_comb begin
        we_eff     = we_i & {NUM_WR{~clr_busy}};
        wdata_d    = wdata_i;
        waddr_oh_d = '0;
        for (int p = 0; p < NUM_WR; p++) begin
            if (we_eff[p] && ((ZERO_REG == 0) || (waddr_i[p] != '0))) begin
                waddr_oh_d[p][waddr_i[p]] = 1'b1;
            end
        end
        if (clr_busy) begin
            wdata_d[0]              = '0;
            waddr_oh_d[0]           = '0;
            waddr_oh_d[0][clr_addr] = 1'b1;
        end
    end

    // Gate enables and outputs are masked by rst_n so no gated edge can occur around reset.
    assign g_en = rst_n & ((|we_eff) | clr_busy);

    cv32e40p_clock_gate u_cg_global (
        .clk_i        (clk_int),
        .en_i         (g_en),
        .scan_cg_en_i (scan_cg_en_i & rst_n),
        .clk_o        (clk_g_raw)
    );

    assign clk_g = clk_g_raw & rst_n;

    always_ff @(posedge clk_g or negedge rst_n) begin
        if (!rst_n) begin
            wdata_q    <= '0;
            waddr_oh_q <= '0;
        end else begin
            wdata_q    <= wdata_d;
            waddr_oh_q <= waddr_oh_d;
        end
    end

    for (genvar w = 0; w < NUM_WORDS; w++) begin : g_word
        if (w < FIRST_WORD) begin : g_zero
            assign mem_rd[w] = '0;
        end else begin : g_rw
            logic                  word_en;
            logic                  clk_w_raw;
            logic                  clk_w;
            logic [DATA_WIDTH-1:0] word_d;
            logic [DATA_WIDTH-1:0] word_q;

            // Enable comes from this cycle's decode; the latch opens in the next high phase.
            always_comb begin
                word_en = 1'b0;
                for (int p = 0; p < NUM_WR; p++) begin
                    word_en = word_en | waddr_oh_d[p][w];
                end
            end

            always_comb begin
                word_d = '0;
                for (int p = 0; p < NUM_WR; p++) begin
                    if (waddr_oh_q[p][w]) begin
                        word_d = wdata_q[p];
                    end
                end
            end

            cv32e40p_clock_gate u_cg_word (
                .clk_i        (clk_g),
                .en_i         (word_en & rst_n),
                .scan_cg_en_i (scan_cg_en_i & rst_n),
                .clk_o        (clk_w_raw)
            );

            assign clk_w = clk_w_raw & rst_n;

            always_latch begin
                if (!rst_n) begin
                    word_q <= '0;
                end else if (clk_w) begin
                    word_q <= word_d;
                end
            end

            assign mem_rd[w] = word_q;
        end
    end

    always_comb begin
        rdata_o = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            rdata_o[r] = mem_rd[raddr_i[r]];
            if (FWD_EN != 0) begin
                for (int p = 0; p < NUM_WR; p++) begin
                    if (waddr_oh_q[p][raddr_i[r]]) begin
                        rdata_o[r] = wdata_q[p];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cv32e40p_regfile_latch_mp.sv
// Bench for the latch register file: vector table, sweep and reset sequences on the default
// configuration, and a randomised reference-model run on a 4-write/6-read non-forwarding instance.
module tb_cv32e40p_regfile_latch_mp;

    logic clk_int = 1'b0;
    always #5 clk_int = ~clk_int;

    logic rst_n;
    logic scan_cg_en;

    logic [2:0][4:0]  raddr_a;
    logic [2:0][31:0] rdata_a;
    logic [1:0][4:0]  waddr_a;
    logic [1:0][31:0] wdata_a;
    logic [1:0]       we_a;
    logic             clr_req_a, busy_a, done_a;

    logic [5:0][5:0]  raddr_b;
    logic [5:0][31:0] rdata_b;
    logic [3:0][5:0]  waddr_b;
    logic [3:0][31:0] wdata_b;
    logic [3:0]       we_b;
    logic             clr_req_b, busy_b, done_b;

    cv32e40p_regfile_latch_mp dut_a (
        .clk_int      (clk_int),
        .rst_n        (rst_n),
        .scan_cg_en_i (scan_cg_en),
        .raddr_i      (raddr_a),
        .rdata_o      (rdata_a),
        .waddr_i      (waddr_a),
        .wdata_i      (wdata_a),
        .we_i         (we_a),
        .clear_req_i  (clr_req_a),
        .clear_busy_o (busy_a),
        .clear_done_o (done_a)
    );

    cv32e40p_regfile_latch_mp #(
        .ADDR_WIDTH (6),
        .NUM_WR     (4),
        .NUM_RD     (6),
        .FWD_EN     (0)
    ) dut_b (
        .clk_int      (clk_int),
        .rst_n        (rst_n),
        .scan_cg_en_i (scan_cg_en),
        .raddr_i      (raddr_b),
        .rdata_o      (rdata_b),
        .waddr_i      (waddr_b),
        .wdata_i      (wdata_b),
        .we_i         (we_b),
        .clear_req_i  (clr_req_b),
        .clear_busy_o (busy_b),
        .clear_done_o (done_b)
    );

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [1:0]       we;
        logic [1:0][4:0]  waddr;
        logic [1:0][31:0] wdata;
        logic [2:0][4:0]  raddr;
        logic [2:0][31:0] rexp;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(input logic [1:0] we, input logic [4:0] a1, input logic [4:0] a0,
                                input logic [31:0] d1, input logic [31:0] d0,
                                input logic [4:0] r2, input logic [4:0] r1, input logic [4:0] r0,
                                input logic [31:0] e2, input logic [31:0] e1, input logic [31:0] e0);
        vec_t v;
        v.we    = we;
        v.waddr = {a1, a0};
        v.wdata = {d1, d0};
        v.raddr = {r2, r1, r0};
        v.rexp  = {e2, e1, e0};
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic sb_check(input string nm, input logic [31:0] act);
        if (exp_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got 0x%08h", nm, act);
        end else begin
            check(nm, act, exp_q.pop_front());
        end
    endtask

    task automatic idle_a();
        we_a      = '0;
        waddr_a   = '0;
        wdata_a   = '0;
        clr_req_a = 1'b0;
    endtask

    task automatic fill_all_a();
        for (int i = 1; i < 32; i += 2) begin
            @(posedge clk_int); #1;
            we_a       = (i + 1 < 32) ? 2'b11 : 2'b01;
            waddr_a[0] = 5'(i);
            wdata_a[0] = 32'hA500_0000 | 32'(i);
            waddr_a[1] = 5'(i + 1);
            wdata_a[1] = 32'hA500_0000 | 32'(i + 1);
        end
        @(posedge clk_int); #1;
        idle_a();
    endtask

    task automatic read_all_zero_a(input string nm);
        for (int i = 0; i < 32; i += 3) begin
            for (int r = 0; r < 3; r++) raddr_a[r] = 5'(i + r);
            @(negedge clk_int);
            for (int r = 0; r < 3; r++) check($sformatf("%s_addr%0d", nm, (i + r) % 32), rdata_a[r], 32'h0);
            @(posedge clk_int); #1;
        end
    endtask

    function automatic logic [5:0] pick_addr();
        if ($urandom_range(0, 1) == 1) return 6'($urandom_range(0, 7));
        return 6'($urandom_range(0, 63));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ref_mem [64];
        int nbusy, ndone, done_at;

        vecs[0]  = mk(2'b01, 5'd0, 5'd5, 32'h0, 32'hDEADBEEF, 5'd5, 5'd5, 5'd5, 32'h0, 32'h0, 32'h0);
        vecs[1]  = mk(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
        vecs[2]  = mk(2'b11, 5'd7, 5'd7, 32'h22222222, 32'h11111111, 5'd0, 5'd5, 5'd7, 32'h0, 32'hDEADBEEF, 32'h0);
        vecs[3]  = mk(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd7, 5'd7, 5'd7, 32'h22222222, 32'h22222222, 32'h22222222);
        vecs[4]  = mk(2'b11, 5'd0, 5'd3, 32'hFFFFFFFF, 32'h00000033, 5'd7, 5'd3, 5'd0, 32'h22222222, 32'h0, 32'h0);
        vecs[5]  = mk(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd0, 32'h0, 32'h00000033, 32'h0);
        vecs[6]  = mk(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        vecs[7]  = mk(2'b11, 5'd1, 5'd31, 32'h01010101, 32'h31313131, 5'd9, 5'd1, 5'd31, 32'h0, 32'h0, 32'h0);
        vecs[8]  = mk(2'b01, 5'd0, 5'd31, 32'h0, 32'hF0F0F0F0, 5'd5, 5'd1, 5'd31, 32'hDEADBEEF, 32'h01010101, 32'h31313131);
        vecs[9]  = mk(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd3, 5'd1, 5'd31, 32'h00000033, 32'h01010101, 32'hF0F0F0F0);
        vecs[10] = mk(2'b01, 5'd8, 5'd7, 32'h87654321, 32'h12345678, 5'd2, 5'd8, 5'd7, 32'h0, 32'h0, 32'h22222222);
        vecs[11] = mk(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd8, 5'd7, 32'hDEADBEEF, 32'h0, 32'h12345678);

        rst_n      = 1'b0;
        scan_cg_en = 1'b0;
        idle_a();
        raddr_a    = {5'd31, 5'd5, 5'd1};
        we_b       = '0;
        waddr_b    = '0;
        wdata_b    = '0;
        raddr_b    = '0;
        clr_req_b  = 1'b0;
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;

        repeat (2) @(negedge clk_int);
        check("reset_busy", 32'(busy_a), 32'h0);
        check("reset_done", 32'(done_a), 32'h0);
        for (int r = 0; r < 3; r++) check($sformatf("reset_rd%0d", r), rdata_a[r], 32'h0);
        @(posedge clk_int); #1;
        rst_n = 1'b1;

        // Directed vectors: one row per cycle, read results checked in the same cycle.
        for (int i = 0; i < 12; i++) begin
            @(posedge clk_int); #1;
            we_a    = vecs[i].we;
            waddr_a = vecs[i].waddr;
            wdata_a = vecs[i].wdata;
            raddr_a = vecs[i].raddr;
            for (int r = 0; r < 3; r++) exp_q.push_back(vecs[i].rexp[r]);
            @(negedge clk_int);
            for (int r = 0; r < 3; r++) sb_check($sformatf("vec%0d_rd%0d", i, r), rdata_a[r]);
        end
        @(posedge clk_int); #1;
        idle_a();

        // Clear sweep with a dropped write and ignored re-requests.
        fill_all_a();
        raddr_a = {5'd31, 5'd16, 5'd1};
        @(negedge clk_int);
        check("fill_rd1", rdata_a[0], 32'hA5000001);
        check("fill_rd16", rdata_a[1], 32'hA5000010);
        check("fill_rd31", rdata_a[2], 32'hA500001F);
        @(posedge clk_int); #1;
        clr_req_a = 1'b1;
        @(negedge clk_int);
        check("req_cycle_busy", 32'(busy_a), 32'h0);
        nbusy = 0; ndone = 0; done_at = -1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk_int); #1;
            clr_req_a  = (c == 10 || c == 31);
            we_a       = (c == 5) ? 2'b01 : 2'b00;
            waddr_a[0] = 5'd4;
            wdata_a[0] = 32'h44444444;
            @(negedge clk_int);
            if (busy_a) nbusy++;
            if (done_a) begin
                ndone++;
                done_at = c;
            end
        end
        check("sweep_busy_cycles", 32'(nbusy), 32'd31);
        check("sweep_done_pulses", 32'(ndone), 32'd1);
        check("sweep_done_cycle", 32'(done_at), 32'd31);
        @(posedge clk_int); #1;
        idle_a();
        read_all_zero_a("after_sweep");

        // Reset in the 10th sweep cycle aborts the sweep silently.
        fill_all_a();
        clr_req_a = 1'b1;
        @(posedge clk_int); #1;
        clr_req_a = 1'b0;
        nbusy = 0;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk_int);
            if (busy_a) nbusy++;
            @(posedge clk_int); #1;
        end
        check("pre_reset_busy_cycles", 32'(nbusy), 32'd9);
        rst_n = 1'b0;
        @(negedge clk_int);
        check("midreset_busy", 32'(busy_a), 32'h0);
        check("midreset_done", 32'(done_a), 32'h0);
        @(posedge clk_int); #1;
        read_all_zero_a("in_reset");
        rst_n = 1'b1;
        nbusy = 0; ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_int);
            if (busy_a) nbusy++;
            if (done_a) ndone++;
            @(posedge clk_int); #1;
        end
        check("post_reset_busy_cycles", 32'(nbusy), 32'd0);
        check("post_reset_done_pulses", 32'(ndone), 32'd0);
        read_all_zero_a("post_reset");

        // Wide non-forwarding instance against a reference model.
        for (int n = 0; n < 300; n++) begin
            @(posedge clk_int); #1;
            for (int p = 0; p < 4; p++) begin
                we_b[p]    = ($urandom_range(0, 2) != 0);
                waddr_b[p] = pick_addr();
                wdata_b[p] = $urandom();
            end
            for (int r = 0; r < 6; r++) begin
                raddr_b[r] = pick_addr();
                exp_q.push_back(ref_mem[raddr_b[r]]);
            end
            @(negedge clk_int);
            for (int r = 0; r < 6; r++) sb_check($sformatf("rand%0d_rd%0d_addr%0d", n, r, raddr_b[r]), rdata_b[r]);
            for (int p = 0; p < 4; p++) begin
                if (we_b[p] && waddr_b[p] != 6'd0) ref_mem[waddr_b[p]] = wdata_b[p];
            end
        end
        @(posedge clk_int); #1;
        we_b = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cv32e40p_regfile_latch_mp.md
CV32E40P_REGFILE_LATCH_MP -- requirements
Module: cv32e40p_regfile_latch_mp

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 5, meaning word address width; NUM_WORDS = 2**ADDR_WIDTH.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning word width.
REQ-003 The block SHALL have parameter NUM_WR, default 2, meaning write port count (1..4).
REQ-004 The block SHALL have parameter NUM_RD, default 3, meaning read port count (1..6).
REQ-005 The block SHALL have parameter ZERO_REG, default 1, meaning word 0 is hardwired to zero and never written.
REQ-006 The block SHALL have parameter FWD_EN, default 1, meaning staged write data is forwarded to read ports.
REQ-007 The block SHALL have port clk_int, input, 1 bit: clock.
REQ-008 The block SHALL have port rst_n, input, 1 bit: reset; asynchronous, active-low; clock clk_int.
REQ-009 The block SHALL have port scan_cg_en_i, input, 1 bit: forces all clock gates open.
REQ-010 The block SHALL have port raddr_i, input, NUM_RD x ADDR_WIDTH: read addresses.
REQ-011 The block SHALL have port rdata_o, output, NUM_RD x DATA_WIDTH: read data.
REQ-012 The block SHALL have ports waddr_i, wdata_i and we_i, inputs, NUM_WR x ADDR_WIDTH, NUM_WR x DATA_WIDTH and NUM_WR x 1: write address, write data and write enable.
REQ-013 The block SHALL have port clear_req_i, input, 1 bit: request to zero all words.
REQ-014 The block SHALL have port clear_busy_o, output, 1 bit: clear sweep in progress.
REQ-015 The block SHALL have port clear_done_o, output, 1 bit: one-cycle pulse at the end of a sweep.

Function
REQ-016 Reads SHALL be combinational: rdata_o[p] = content of word raddr_i[p]; with ZERO_REG=1, address 0 SHALL return 0.
REQ-017 A write presented in cycle N SHALL be sampled into per-port staging registers (data, one-hot address) on the posedge ending cycle N.
REQ-018 The target latch SHALL be opened by a per-word gated clock during the high phase of cycle N+1.
REQ-019 A write in cycle N SHALL NOT be visible on rdata_o in cycle N.
REQ-020 A write in cycle N SHALL be visible on rdata_o in cycle N+1: from the staging register when FWD_EN=1, otherwise from the latch after it opens.
REQ-021 When several ports write the same address in one cycle, the highest-index port SHALL win; this applies to both storage and forwarding.
REQ-022 With ZERO_REG=1, writes to address 0 SHALL be discarded and SHALL NOT be forwarded.
REQ-023 A global clock gate SHALL enable clk_int-derived clocks only when any we_i is set or the clear sweep is active.
REQ-024 The clear FSM SHALL have three states: IDLE, SWEEP and DONE.
REQ-025 In IDLE, clear_req_i=1 SHALL move the FSM to SWEEP with the counter at the first writable word.
REQ-026 In SWEEP, the FSM SHALL write zero to word[counter] through the staging path, one word per cycle.
REQ-027 In SWEEP at NUM_WORDS-1, the FSM SHALL move to DONE; DONE SHALL last one cycle and then return to IDLE.
REQ-028 clear_busy_o SHALL be 1 exactly while the FSM is in SWEEP; clear_done_o SHALL be 1 exactly while it is in DONE.
REQ-029 External writes presented while clear_busy_o=1 SHALL be dropped.
REQ-030 clear_req_i SHALL be ignored outside IDLE.
REQ-031 A sweep SHALL take NUM_WORDS-ZERO_REG cycles in SWEEP.
REQ-032 The counter SHALL be ADDR_WIDTH bits wide and SHALL NOT wrap.

Reset
REQ-033 While rst_n=0, all words, staging registers and the counter SHALL be 0 and the FSM SHALL be in IDLE.
REQ-034 While rst_n=0, rdata_o SHALL be 0 for every port, and clear_busy_o and clear_done_o SHALL be 0.
REQ-035 Reset asserted mid-sweep SHALL abort the sweep without a clear_done_o pulse.
REQ-036 Reset release SHALL be glitch-free relative to the latch enables: all gated clocks SHALL be low while rst_n=0.

Structure
REQ-037 Package cv32e40p_regfile_pkg SHALL hold the clear FSM state enum and the default parameter constants.
REQ-038 Clock gating SHALL use the existing cv32e40p_clock_gate: one global instance plus one per writable word.
REQ-039 The clear FSM and counter SHALL be sub-module cv32e40p_regfile_clear_fsm.
REQ-040 Storage SHALL be latches transparent while the word clock is high; no flip-flop storage array.

Verification
REQ-041 Write port 0, address 5, data 0xDEADBEEF in cycle 0 -> raddr 5 reads the old value in cycle 0 and 0xDEADBEEF from cycle 1 on all read ports.
REQ-042 Port 0 writes 0x11111111 and port 1 writes 0x22222222, both to address 7, in the same cycle -> address 7 holds 0x22222222.
REQ-043 Write 0xFFFFFFFF to address 0 with ZERO_REG=1 -> address 0 reads 0 in every later cycle.
REQ-044 Fill all words with nonzero values, then pulse clear_req_i -> clear_busy_o is high for 31 cycles, clear_done_o pulses once, all reads return 0, and a write issued during the sweep is lost.
REQ-045 Assert rst_n=0 at the 10th cycle of a sweep -> busy and done are 0, all words read 0, and no done pulse occurs.
REQ-046 Configuration NUM_WR=4, NUM_RD=6, ADDR_WIDTH=6, FWD_EN=0: random writes checked against a reference model, with read-after-write one cycle later.
